// File: rtl/detector_pico.sv
// Purpose : per-window peak detector for correlator output; reports the window maximum and its position when it meets UMBRAL.
// Latency : Window_Done / Peak_Flag / Peak_* update one cycle after the edge that takes the closing sample.
// Backpressure: none; samples are rising edges of Flag_In and are never stalled. Results are one-cycle pulses plus held values.
//
// Ports:
//   Clk, Reset        clock, asynchronous active-low reset
//   Data_In, Flag_In  correlation value and its valid flag (a 0->1 edge is one sample)
//   Clear             synchronous discard of the partial window (wins over a same-edge sample)
//   Peak_Value/Index  maximum of the last detecting window and its 0-based position
//   Peak_Flag         pulse: the window just closed met the threshold
//   Window_Done       pulse: a window just closed
//   Peak_Count        detecting windows since reset, saturating at 255
module detector_pico #(
   parameter int              ANCHO   = 11,
   parameter int              VENTANA = 24,
   parameter int              IDX_W   = 5,
   parameter logic [ANCHO-1:0] UMBRAL = ANCHO'(1000)
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic [ANCHO-1:0] Data_In,
   input  logic             Flag_In,
   input  logic             Clear,
   output logic [ANCHO-1:0] Peak_Value,
   output logic [IDX_W-1:0] Peak_Index,
   output logic             Peak_Flag,
   output logic             Window_Done,
   output logic [7:0]       Peak_Count
);

   typedef enum logic {IDLE = 1'b0, ACUM = 1'b1} state_t;

   // One extra bit so that VENTANA = 2^IDX_W is representable.
   localparam logic [IDX_W:0] VENT_C = (IDX_W+1)'(VENTANA);
   localparam logic [IDX_W:0] ONE_C  = (IDX_W+1)'(1);

   state_t           state_q, state_d;
   logic             flag_q;
   logic [IDX_W:0]   cnt_q, cnt_d;
   logic [ANCHO-1:0] max_q, max_d;
   logic [IDX_W-1:0] idx_q, idx_d;

   logic [ANCHO-1:0] pval_q;
   logic [IDX_W-1:0] pidx_q;
   logic [7:0]       pcnt_q;
   logic             pflag_q;
   logic             done_q;

   logic             samp;
   logic [IDX_W:0]   cnt_inc;
   logic             last_samp;
   logic             close_c;
   logic             det_c;

   // A sample is the rising edge of Flag_In; a flag held high counts once.
   assign samp      = Flag_In & ~flag_q;
   assign cnt_inc   = cnt_q + ONE_C;
   assign last_samp = (cnt_inc == VENT_C);

   // ---------------- FSM: state register ----------------
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------- FSM: next-state logic ----------------
   always_comb begin
      state_d = state_q;
      if (Clear) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE:    if (samp) state_d = ACUM;
            ACUM:    if (samp && last_samp) state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   // ---------------- FSM: output logic ----------------
   // The closing sample is part of the compare, so the threshold test
   // looks at the updated maximum rather than the registered one.
   always_comb begin
      close_c = 1'b0;
      det_c   = 1'b0;
      if (!Clear && (state_q == ACUM) && samp && last_samp) begin
         close_c = 1'b1;
         det_c   = (max_d >= UMBRAL);
      end
   end

   // ---------------- window accumulator ----------------
   always_comb begin
      cnt_d = cnt_q;
      max_d = max_q;
      idx_d = idx_q;
      if (Clear) begin
         cnt_d = '0;
      end else if (samp) begin
         if (state_q == IDLE) begin
            max_d = Data_In;
            idx_d = '0;
            cnt_d = ONE_C;
         end else begin
            // Strict compare: a tie keeps the earlier position.
            if (Data_In > max_q) begin
               max_d = Data_In;
               idx_d = cnt_q[IDX_W-1:0];
            end
            cnt_d = last_samp ? '0 : cnt_inc;
         end
      end
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         flag_q <= 1'b0;
         cnt_q  <= '0;
         max_q  <= '0;
         idx_q  <= '0;
      end else begin
         flag_q <= Flag_In;
         cnt_q  <= cnt_d;
         max_q  <= max_d;
         idx_q  <= idx_d;
      end
   end

   // ---------------- result registers ----------------
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         pval_q  <= '0;
         pidx_q  <= '0;
         pcnt_q  <= '0;
         pflag_q <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q  <= close_c;
         pflag_q <= det_c;
         if (det_c) begin
            pval_q <= max_d;
            pidx_q <= idx_d;
            if (pcnt_q != 8'hFF) begin
               pcnt_q <= pcnt_q + 8'd1;
            end
         end
      end
   end

   assign Peak_Value  = pval_q;
   assign Peak_Index  = pidx_q;
   assign Peak_Count  = pcnt_q;
   assign Peak_Flag   = pflag_q;
   assign Window_Done = done_q;

endmodule

// File: doc/detector_pico.md
DETECTOR_PICO -- requirements
Module: detector_pico

Interface
REQ-001 Parameter ANCHO, default 11: width of the correlation value input and of Peak_Value.
REQ-002 Parameter VENTANA, default 24: number of correlation samples per detection window (legal range 2..2^IDX_W).
REQ-003 Parameter IDX_W, default 5: width of Peak_Index.
REQ-004 Parameter UMBRAL, default 11'd1000: detection threshold, unsigned, ANCHO bits.
REQ-005 Clk  input  1  single clock; all state updates on the rising edge.
REQ-006 Reset  input  1  asynchronous, active-low reset.
REQ-007 Data_In  input  ANCHO  unsigned correlation value from the upstream correlator.
REQ-008 Flag_In  input  1  correlator valid flag; may stay high for several cycles; each 0->1 transition is one sample.
REQ-009 Clear  input  1  synchronous discard of the current partial window.
REQ-010 Peak_Value  output  ANCHO  maximum value of the last detecting window.
REQ-011 Peak_Index  output  IDX_W  position (0-based) of that maximum within its window.
REQ-012 Peak_Flag  output  1  one-cycle pulse: the window just closed met the threshold.
REQ-013 Window_Done  output  1  one-cycle pulse: a window just closed.
REQ-014 Peak_Count  output  8  number of detecting windows since reset, saturating at 255.

Function
REQ-015 The block SHALL register Flag_In every cycle (flag_d) and define a sample event as Flag_In=1 AND flag_d=0, sampled at the clock edge.
REQ-016 The block SHALL capture Data_In on the same edge that detects the event; Data_In SHALL NOT be sampled on any other edge.
REQ-017 The FSM SHALL have two states, IDLE and ACUM; reset state is IDLE.
REQ-018 IDLE + event: the block SHALL load max=Data_In, idx=0, cnt=1 and go to ACUM.
REQ-019 ACUM + event: if Data_In > max (strict), the block SHALL load max=Data_In, idx=cnt; cnt SHALL increment by 1.
REQ-020 Ties SHALL keep the earliest index.
REQ-021 On the event that brings cnt to VENTANA, the block SHALL close the window, including that sample in the compare, and return to IDLE.
REQ-022 Window_Done SHALL be high for exactly the one cycle after the closing edge (latency 1 cycle).
REQ-023 At close, if the final max >= UMBRAL, the block SHALL in the same cycle as Window_Done:
  - pulse Peak_Flag;
  - load Peak_Value=max and Peak_Index=idx;
  - increment Peak_Count unless it already equals 255.
REQ-024 At close with max < UMBRAL, Peak_Value, Peak_Index and Peak_Count SHALL hold their prior values.
REQ-025 Peak_Value and Peak_Index SHALL hold until the next detecting window.
REQ-026 Clear=1 SHALL force IDLE and cnt=0, and SHALL discard any event on the same edge (Clear has priority).
REQ-027 Clear SHALL NOT alter Peak_Value, Peak_Index or Peak_Count.
REQ-028 Clear on the closing edge SHALL suppress Window_Done and Peak_Flag.
REQ-029 An event on the cycle after the closing edge SHALL start a new window normally; no sample SHALL be lost.
REQ-030 All comparisons SHALL be unsigned at ANCHO bits; cnt SHALL be IDX_W+1 bits wide so that VENTANA=2^IDX_W does not wrap.

Reset
REQ-031 Reset low SHALL immediately force:
  - state IDLE;
  - flag_d=0, cnt=0, max=0, idx=0;
  - Peak_Value=0, Peak_Index=0, Peak_Count=0, Peak_Flag=0, Window_Done=0.
REQ-032 Reset low mid-window SHALL discard the partial window.
REQ-033 After release, Flag_In already high SHALL count as one event on the first edge.

Verification (bench parameters: VENTANA=4, UMBRAL=1010)
REQ-034 Samples 1011, 1012, 1017, 900 -> Window_Done and Peak_Flag pulse together one cycle after the 4th event; Peak_Value=1017, Peak_Index=2, Peak_Count=1.
REQ-035 Next window 500, 600, 700, 800 -> Window_Done pulses, Peak_Flag stays 0; Peak_Value=1017, Peak_Index=2, Peak_Count=1 unchanged.
REQ-036 Samples 1020, 1020, 3, 4 -> Peak_Index=0 (tie keeps the earliest), Peak_Value=1020.
REQ-037 Flag_In held high 5 cycles with Data_In changing each cycle -> counted as exactly one sample, with the value present on the rising-edge cycle.
REQ-038 Two samples, then Clear, then 1015, 1, 2, 3 -> a single Window_Done after the 6th event overall; Peak_Value=1015, Peak_Index=0.
REQ-039 Reset driven low after 3 samples of a window -> all outputs 0 at once; after release, 4 new samples close exactly one window; 256 detecting windows -> Peak_Count saturates at 255.
